// File: rtl/axi_pkg.sv
// Shared AXI read-arbiter types: FSM states, burst and response encodings.
// Imported by the interface, the arbiter core and the round-robin picker.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read channel bundle (AR + R) between one master and one slave.
// master drives AR and rready; slave drives arready and the R beat.
interface axi_read_arbiter_if
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  burst_t            arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  resp_t             rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the
// master that was not granted last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = (last == 2'b01) ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one downstream AXI read port between icache (m0) and LSU (m1),
// one outstanding burst at a time, with rlast/beat-count checking.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s,
  output logic [1:0]         grant,
  output logic               len_err
);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        req;
  logic [1:0]        gnt_rr;
  logic [1:0]        last;
  logic [7:0]        beat;
  logic [7:0]        len_q;
  logic              g0;
  logic              g1;
  logic              ar_hs;
  logic              r_hs;
  logic [ADDR_W-1:0] araddr_sel;
  logic [DATA_W-1:0] rdata_fwd;

  assign req   = {m1.arvalid, m0.arvalid};
  assign g0    = grant[0];
  assign g1    = grant[1];
  assign ar_hs = s.arvalid && s.arready;
  assign r_hs  = s.rvalid && s.rready;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (last),
    .gnt  (gnt_rr)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (|req) state_nx = ST_ADDR;
      ST_ADDR: if (ar_hs) state_nx = ST_DATA;
      ST_DATA: if (r_hs && s.rlast) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // beat counter saturates at arlen so a late rlast cannot wrap it
  always_ff @(posedge clock) begin
    if (reset) begin
      grant   <= 2'b00;
      last    <= 2'b10;
      beat    <= 8'd0;
      len_q   <= 8'd0;
      len_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state)
        ST_IDLE: if (|req) grant <= gnt_rr;
        ST_ADDR: begin
          if (ar_hs) begin
            len_q <= s.arlen;
            beat  <= 8'd0;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            len_err <= (s.rlast && beat != len_q) ||
                       (!s.rlast && beat == len_q);
            if (beat != len_q) beat <= beat + 8'd1;
            if (s.rlast) begin
              last  <= grant;
              grant <= 2'b00;
            end
          end
        end
        default: grant <= 2'b00;
      endcase
    end
  end

  assign araddr_sel = g1 ? m1.araddr : m0.araddr;
  assign rdata_fwd  = s.rdata;

  always_comb begin
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    s.araddr   = araddr_sel;
    s.arlen    = g1 ? m1.arlen   : m0.arlen;
    s.arsize   = g1 ? m1.arsize  : m0.arsize;
    s.arburst  = g1 ? m1.arburst : m0.arburst;
    m0.rdata   = rdata_fwd;
    m1.rdata   = rdata_fwd;
    m0.rresp   = s.rresp;
    m1.rresp   = s.rresp;
    m0.rlast   = s.rlast;
    m1.rlast   = s.rlast;
    if (!reset) begin
      unique case (state)
        ST_ADDR: begin
          s.arvalid  = (g0 && m0.arvalid) || (g1 && m1.arvalid);
          m0.arready = g0 && s.arready;
          m1.arready = g1 && s.arready;
        end
        ST_DATA: begin
          s.rready  = (g0 && m0.rready) || (g1 && m1.rready);
          m0.rvalid = g0 && s.rvalid;
          m1.rvalid = g1 && s.rvalid;
        end
        default: ;
      endcase
    end
  end

endmodule
